// File: rtl/boron_pkg.sv
// Shared types and constants for the Boron job scheduler.
package boron_pkg;

  localparam int BORON_BLK_W = 64;
  localparam int BORON_KEY_W = 80;

  // Engine direction, carried from the request into the job registers
  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } boron_mode_e;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } sched_state_e;

  // Converts the raw request mode bit into the mode enum
  function automatic boron_mode_e to_mode(input logic i_bit);
    to_mode = i_bit ? DEC : ENC;
  endfunction

endpackage

// File: rtl/boron_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting one past the last
// granted requester, plus the last_grant register that moves on accept.
module boron_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_index,
  output logic            o_any
);

  logic [ID_W-1:0] r_last_grant;
  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_index;
  logic            w_any;
  int              w_pos;

  // Search from last_grant+1 with wrap; first valid requester wins
  always_comb begin
    w_grant = '0;
    w_index = '0;
    w_any   = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = int'(r_last_grant) + k;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end else begin
        w_pos = w_pos;
      end
      if (!w_any && i_req[ID_W'(w_pos)]) begin
        w_grant[ID_W'(w_pos)] = 1'b1;
        w_index               = ID_W'(w_pos);
        w_any                 = 1'b1;
      end else begin
        w_any = w_any;
      end
    end
  end

  // Remember the winner; reset points at the last slot so requester 0 goes first
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(NREQ - 1);
    end else if (i_accept) begin
      r_last_grant <= w_index;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign o_grant = w_grant;
  assign o_index = w_index;
  assign o_any   = w_any;

endmodule

// File: rtl/boron_job_scheduler.sv
// Shares one Boron encrypt/decrypt engine between NREQ requesters.
// Each accepted job re-arms the engine (one-cycle reset), starts it, waits
// for the level finish flag or a timeout, and returns a tagged response.
module boron_job_scheduler
  import boron_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 128,
  parameter int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0]             req_mode,
  input  logic [NREQ*BORON_BLK_W-1:0] req_text,
  input  logic [NREQ*BORON_KEY_W-1:0] req_key,
  output logic                        eng_rst,
  output logic                        eng_start,
  output logic                        eng_mode,
  output logic [BORON_BLK_W-1:0]      eng_text,
  output logic [BORON_KEY_W-1:0]      eng_key,
  input  logic                        eng_fin,
  input  logic [BORON_BLK_W-1:0]      eng_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [BORON_BLK_W-1:0]      rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [15:0]                 jobs_done
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  sched_state_e r_state;
  sched_state_e w_next_state;

  // Job registers hold the accepted request for the whole job
  boron_mode_e            r_job_mode;
  logic [BORON_BLK_W-1:0] r_job_text;
  logic [BORON_KEY_W-1:0] r_job_key;
  logic [ID_W-1:0]        r_job_id;

  logic [BORON_BLK_W-1:0] r_rsp_data;
  logic [ID_W-1:0]        r_rsp_id;
  logic                   r_rsp_err;
  logic [15:0]            r_jobs_done;
  logic [CNT_W-1:0]       r_cnt;

  logic [NREQ-1:0]        w_grant;
  logic [ID_W-1:0]        w_index;
  logic                   w_any;
  logic                   w_accept;
  logic                   w_idle_open;

  logic                   w_sel_mode;
  logic [BORON_BLK_W-1:0] w_sel_text;
  logic [BORON_KEY_W-1:0] w_sel_key;

  logic                   w_eng_clear;
  logic                   w_eng_start;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_cap_ok;
  logic                   w_cap_err;
  logic                   w_rsp_valid;
  logic                   w_rsp_fire;

  // Grants are only offered in IDLE and never while reset is high
  assign w_idle_open = (r_state == S_IDLE) && !reset;
  assign w_accept    = w_idle_open && w_any;
  assign req_ready   = w_idle_open ? w_grant : '0;

  boron_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_index  (w_index),
    .o_any    (w_any)
  );

  // One-hot AND-OR mux of the granted requester's mode, text and key
  always_comb begin
    w_sel_mode = 1'b0;
    w_sel_text = '0;
    w_sel_key  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_mode = w_sel_mode | (req_mode[i] & w_grant[i]);
      w_sel_text = w_sel_text | (req_text[i*BORON_BLK_W +: BORON_BLK_W] & {BORON_BLK_W{w_grant[i]}});
      w_sel_key  = w_sel_key  | (req_key[i*BORON_KEY_W +: BORON_KEY_W]  & {BORON_KEY_W{w_grant[i]}});
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and per-state control decode; eng_fin only matters in WAIT
  // because a stale finish from the previous job is still high elsewhere
  always_comb begin
    w_next_state = r_state;
    w_eng_clear  = 1'b0;
    w_eng_start  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cap_ok     = 1'b0;
    w_cap_err    = 1'b0;
    w_rsp_valid  = 1'b0;
    w_rsp_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_CLEAR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_eng_clear  = 1'b1;
        w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_eng_start  = 1'b1;
        w_cnt_clr    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_inc = 1'b1;
        if (eng_fin) begin
          w_cap_ok     = 1'b1;
          w_next_state = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_cap_err    = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_fire   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the granted request on the accept cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_job_mode <= ENC;
      r_job_text <= '0;
      r_job_key  <= '0;
      r_job_id   <= '0;
    end else if (w_accept) begin
      r_job_mode <= to_mode(w_sel_mode);
      r_job_text <= w_sel_text;
      r_job_key  <= w_sel_key;
      r_job_id   <= w_index;
    end else begin
      r_job_mode <= r_job_mode;
      r_job_text <= r_job_text;
      r_job_key  <= r_job_key;
      r_job_id   <= r_job_id;
    end
  end

  // Timeout counter: cleared in LAUNCH, counts every WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Response registers load on leaving WAIT and hold through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_cap_ok) begin
      r_rsp_data <= eng_result;
      r_rsp_id   <= r_job_id;
      r_rsp_err  <= 1'b0;
    end else if (w_cap_err) begin
      r_rsp_data <= '0;
      r_rsp_id   <= r_job_id;
      r_rsp_err  <= 1'b1;
    end else begin
      r_rsp_data <= r_rsp_data;
      r_rsp_id   <= r_rsp_id;
      r_rsp_err  <= r_rsp_err;
    end
  end

  // Completed-response counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jobs_done <= '0;
    end else if (w_rsp_fire) begin
      r_jobs_done <= r_jobs_done + 16'd1;
    end else begin
      r_jobs_done <= r_jobs_done;
    end
  end

  assign eng_rst   = reset | w_eng_clear;
  assign eng_start = w_eng_start;
  assign eng_mode  = r_job_mode;
  assign eng_text  = r_job_text;
  assign eng_key   = r_job_key;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);
  assign jobs_done = r_jobs_done;

endmodule

// File: tb/tb_boron_job_scheduler.sv
// Directed bench for boron_job_scheduler with a behavioural engine model
// and a response scoreboard.
module tb_boron_job_scheduler;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 1;
  localparam int ENG_LAT = 52;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_mode;
  logic [NREQ*64-1:0]  req_text;
  logic [NREQ*80-1:0]  req_key;
  logic                eng_rst;
  logic                eng_start;
  logic                eng_mode;
  logic [63:0]         eng_text;
  logic [79:0]         eng_key;
  logic                eng_fin;
  logic [63:0]         eng_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_err;
  logic                busy;
  logic [15:0]         jobs_done;

  logic [63:0] txt [NREQ];
  logic [79:0] key [NREQ];
  logic        mde [NREQ];

  assign req_text = {txt[1], txt[0]};
  assign req_key  = {key[1], key[0]};
  assign req_mode = {mde[1], mde[0]};

  boron_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_text(req_text), .req_key(req_key),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_mode(eng_mode),
    .eng_text(eng_text), .eng_key(eng_key), .eng_fin(eng_fin),
    .eng_result(eng_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the cipher: any fixed function of mode/text/key will do
  function automatic logic [63:0] eng_model(input logic m, input logic [63:0] t, input logic [79:0] k);
    if (m) eng_model = {t[31:0], t[63:32]} ^ k[79:16];
    else   eng_model = t ^ k[63:0] ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Engine model: fin rises ENG_LAT cycles after start, level until eng_rst
  logic        model_fin  = 1'b0;
  logic        model_run  = 1'b0;
  logic        model_hang = 1'b0;
  logic        fin_flip   = 1'b0;
  int          model_cnt  = 0;
  logic [63:0] model_res  = 64'd0;

  always @(posedge clk) begin
    if (eng_rst) begin
      model_fin <= 1'b0;
      model_run <= 1'b0;
      model_cnt <= 0;
    end else if (eng_start) begin
      model_run <= 1'b1;
      model_cnt <= 1;
      model_res <= eng_model(eng_mode, eng_text, eng_key);
    end else if (model_run) begin
      if (model_cnt == ENG_LAT - 1 && !model_hang) begin
        model_fin <= 1'b1;
        model_run <= 1'b0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  assign eng_fin    = model_fin ^ fin_flip;
  assign eng_result = model_res;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic            err;
  } sb_t;

  sb_t sb_q[$];
  sb_t last_exp;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  jobs_exp = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for the accept cycle and leaves the bench in that cycle
  task automatic wait_accept(input int exp_id, input bit exp_err, input bit do_push, output int t);
    bit          got;
    logic [1:0]  exp_oh;
    sb_t         item;
    got = 1'b0;
    #1;
    for (int k = 0; k < 64 && !got; k++) begin
      if ((req_ready & req_valid) != '0) got = 1'b1;
      else tick();
    end
    check("accept_seen", {79'd0, got}, 80'd1);
    exp_oh = 2'b01 << exp_id;
    check("grant_onehot", {78'd0, req_ready}, {78'd0, exp_oh});
    t = cyc;
    if (do_push) begin
      item.id   = ID_W'(exp_id);
      item.err  = exp_err;
      item.data = exp_err ? 64'd0 : eng_model(mde[exp_id], txt[exp_id], key[exp_id]);
      sb_q.push_back(item);
    end
  endtask

  task automatic wait_rsp(output int r);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 150 && !got; k++) begin
      if (rsp_valid) got = 1'b1;
      else tick();
    end
    check("rsp_seen", {79'd0, got}, 80'd1);
    r = cyc;
  endtask

  task automatic check_rsp();
    check("sb_nonempty", {79'd0, sb_q.size() != 0}, 80'd1);
    if (sb_q.size() != 0) begin
      last_exp = sb_q.pop_front();
      check("rsp_id", {79'd0, rsp_id}, {79'd0, last_exp.id});
      check("rsp_data", {16'd0, rsp_data}, {16'd0, last_exp.data});
      check("rsp_err", {79'd0, rsp_err}, {79'd0, last_exp.err});
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    jobs_exp++;
    check("jobs_done", {64'd0, jobs_done}, 80'(jobs_exp));
    check("idle_after_rsp", {79'd0, busy}, 80'd0);
    check("rsp_dropped", {79'd0, rsp_valid}, 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;
    int r_prev;
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    txt[0] = 64'h1111_2222_3333_4444; key[0] = 80'hAAAA_0000_BBBB_1111_CCCC; mde[0] = 1'b0;
    txt[1] = 64'h5555_6666_7777_8888; key[1] = 80'h1234_5678_9ABC_DEF0_1357; mde[1] = 1'b1;
    tick(); tick(); tick();
    check("ready_in_reset", {78'd0, req_ready}, 80'd0);
    check("eng_rst_in_reset", {79'd0, eng_rst}, 80'd1);
    check("busy_in_reset", {79'd0, busy}, 80'd0);
    req_valid = 2'b00;
    reset     = 1'b0;
    tick();
    check("rst_rsp_valid", {79'd0, rsp_valid}, 80'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 80'd0);
    check("rst_rsp_id", {79'd0, rsp_id}, 80'd0);
    check("rst_rsp_err", {79'd0, rsp_err}, 80'd0);
    check("rst_jobs_done", {64'd0, jobs_done}, 80'd0);
    check("rst_eng_start", {79'd0, eng_start}, 80'd0);
    check("rst_eng_rst", {79'd0, eng_rst}, 80'd0);
    check("rst_eng_key", eng_key, 80'd0);

    // Reset in WAIT aborts silently and restores requester 0 priority
    req_valid = 2'b01;
    wait_accept(0, 1'b0, 1'b0, t);
    tick();
    req_valid = 2'b00;
    check("abort_clear_rst", {79'd0, eng_rst}, 80'd1);
    tick();
    check("abort_start", {79'd0, eng_start}, 80'd1);
    tick(); tick(); tick(); tick();
    check("abort_busy_wait", {79'd0, busy}, 80'd1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rr_after_reset", {78'd0, req_ready}, 80'd1);
    check("abort_jobs_done", {64'd0, jobs_done}, 80'd0);
    req_valid = 2'b00;
    tick(); tick(); tick();
    check("abort_no_rsp", {79'd0, rsp_valid}, 80'd0);
    check("abort_idle", {79'd0, busy}, 80'd0);

    // Single encrypt, all-zero text and key
    txt[0] = 64'd0; key[0] = 80'd0; mde[0] = 1'b0;
    req_valid = 2'b01;
    wait_accept(0, 1'b0, 1'b1, t);
    tick();
    req_valid = 2'b00;
    check("enc_eng_rst_t1", {79'd0, eng_rst}, 80'd1);
    check("enc_no_start_t1", {79'd0, eng_start}, 80'd0);
    check("enc_busy", {79'd0, busy}, 80'd1);
    tick();
    check("enc_start_t2", {79'd0, eng_start}, 80'd1);
    check("enc_no_rst_t2", {79'd0, eng_rst}, 80'd0);
    wait_rsp(r);
    check("enc_latency", 80'(r - t), 80'(ENG_LAT + 3));
    check_rsp();
    handshake();

    // Timeout on requester 1: engine never finishes
    model_hang = 1'b1;
    req_valid  = 2'b10;
    wait_accept(1, 1'b1, 1'b1, t);
    tick();
    req_valid = 2'b00;
    wait_rsp(r);
    check("timeout_latency", 80'(r - t), 80'(TIMEOUT + 3));
    check_rsp();
    handshake();
    model_hang = 1'b0;

    // Fairness: both requesters continuously valid for six jobs
    txt[0] = 64'hDEAD_BEEF_0BAD_F00D; key[0] = 80'h0F0F_1E1E_2D2D_3C3C_4B4B; mde[0] = 1'b0;
    txt[1] = 64'hCAFE_BABE_1234_5678; key[1] = 80'h9999_AAAA_BBBB_CCCC_DDDD; mde[1] = 1'b1;
    req_valid = 2'b11;
    r_prev = 0;
    for (int j = 0; j < 6; j++) begin
      wait_accept(j % 2, 1'b0, 1'b1, t);
      if (j > 0) check("rr_gap", 80'(t - r_prev), 80'd1);
      tick();
      wait_rsp(r);
      check("rr_latency", 80'(r - t), 80'(ENG_LAT + 3));
      check_rsp();
      handshake();
      r_prev = r;
    end

    // Backpressure: hold DONE for 20 cycles while eng_fin wiggles
    wait_accept(0, 1'b0, 1'b1, t);
    tick();
    wait_rsp(r);
    check_rsp();
    for (int k = 0; k < 20; k++) begin
      fin_flip = k[0];
      tick();
      check("bp_valid", {79'd0, rsp_valid}, 80'd1);
      check("bp_data", {16'd0, rsp_data}, {16'd0, last_exp.data});
      check("bp_id", {79'd0, rsp_id}, {79'd0, last_exp.id});
      check("bp_err", {79'd0, rsp_err}, 80'd0);
      check("bp_ready_low", {78'd0, req_ready}, 80'd0);
      check("bp_eng_text", {16'd0, eng_text}, {16'd0, txt[0]});
    end
    fin_flip = 1'b0;
    handshake();

    // Stale fin: high through CLEAR (previous job) and LAUNCH (forced)
    wait_accept(1, 1'b0, 1'b1, t);
    tick();
    req_valid = 2'b00;
    tick();
    fin_flip = 1'b1;
    check("stale_start", {79'd0, eng_start}, 80'd1);
    tick();
    fin_flip = 1'b0;
    check("stale_no_rsp_t3", {79'd0, rsp_valid}, 80'd0);
    tick();
    check("stale_no_rsp_t4", {79'd0, rsp_valid}, 80'd0);
    check("stale_busy_t4", {79'd0, busy}, 80'd1);
    wait_rsp(r);
    check("stale_latency", 80'(r - t), 80'(ENG_LAT + 3));
    check_rsp();
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boron_job_scheduler.md
# boron_job_scheduler

Shares one Boron cipher engine (64-bit block, 80-bit key; encrypt and decrypt controllers behind a mode select) between NREQ requesters. Arbitration is round-robin. For each accepted job the block re-arms the engine with a one-cycle engine reset, launches it with a one-cycle start pulse, and waits for the engine's level-high finish flag. It returns the result, or a timeout error, on a valid/ready response port tagged with the requester id. It sits between the bus-side request queues and the Boron encrypt/decrypt datapath.

## Interface
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 128, max cycles in WAIT before error (≥ 64; the engine needs ~52 cycles per job)
- ID_W, max(1,$clog2(NREQ)), requester id width (derived)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  one-hot grant/accept
- req_mode  in  NREQ  per requester: 0 encrypt, 1 decrypt
- req_text  in  NREQ*64  plaintext/ciphertext, requester i at [64i+:64]
- req_key  in  NREQ*80  key, requester i at [80i+:80]
- eng_rst  out  1  engine synchronous reset
- eng_start  out  1  engine start pulse
- eng_mode  out  1  selects encrypt/decrypt engine
- eng_text  out  64  engine input block
- eng_key  out  80  engine input key
- eng_fin  in  1  engine finish, level, held until eng_rst
- eng_result  in  64  engine output block
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  64  result block (0 on error)
- rsp_id  out  ID_W  requester index of the job
- rsp_err  out  1  1 = timeout
- busy  out  1  state ≠ IDLE
- jobs_done  out  16  count of completed responses, wraps

## Operation
- FSM states are IDLE, CLEAR, LAUNCH, WAIT, DONE.
- IDLE: the arbiter picks the first i with req_valid[i], searching from last_grant+1 with wrap. req_ready[i]=1 only for that i and only in IDLE. On the accept cycle the block latches mode/text/key/id into the job registers, sets last_grant=i, and moves to CLEAR.
- CLEAR: eng_rst=1 for exactly one cycle, then LAUNCH.
- LAUNCH: eng_start=1 for exactly one cycle. Clear the timeout counter, then WAIT.
- WAIT: the counter increments every cycle.
  - eng_fin=1: capture eng_result into rsp_data, set rsp_err=0, go to DONE.
  - Counter reaches TIMEOUT-1 with eng_fin=0: set rsp_data=0, rsp_err=1, go to DONE.
  - eng_fin and timeout in the same cycle: eng_fin wins.
- DONE: rsp_valid=1. rsp_data, rsp_id and rsp_err stay stable until rsp_ready. On rsp_valid&&rsp_ready, jobs_done+1 (16-bit wrap) and go to IDLE.
- eng_fin is ignored in IDLE, CLEAR, LAUNCH and DONE, because a stale Fin from the previous job is still high there.
- eng_mode, eng_text and eng_key are driven from the job registers and stay constant from CLEAR through DONE.
- eng_rst = reset OR (state==CLEAR).
- Reset values:
  - state=IDLE; last_grant=NREQ-1, so requester 0 wins first.
  - Job registers, rsp_data, rsp_id, rsp_err and jobs_done are 0.
  - req_ready=0 while reset=1. eng_start=0, rsp_valid=0, busy=0.
- Reset mid-job aborts it silently: no response, and jobs_done is unchanged.

## Timing
- Accept at cycle T (req_valid[i]&&req_ready[i]).
- eng_rst high at T+1, eng_start high at T+2, WAIT from T+3.
- eng_fin first sampled high at cycle F gives rsp_valid at F+1.
- Response handshake at cycle R gives IDLE at R+1. The earliest next accept is R+1, so there is one idle cycle between jobs.
- Timeout response: rsp_valid at T+3+TIMEOUT.
- req_ready is combinational from req_valid and last_grant in IDLE. All other outputs are registered or decoded from state.
- No requester is granted twice while another is continuously valid (round-robin fairness).

## Structure
- Package boron_pkg holds:
  - BORON_BLK_W=64 and BORON_KEY_W=80
  - mode enum (ENC=0, DEC=1)
  - the scheduler state enum
- Sub-module boron_rr_arbiter holds the combinational round-robin pick plus the last_grant register. It is parameterised by NREQ and outputs a one-hot grant and a binary index.
- The FSM, timeout counter, job registers and response registers live in boron_job_scheduler.

## Test plan
- Single encrypt: requester 0, text 64'h0, key 80'h0. Engine model asserts fin 52 cycles after start. Required: eng_rst at T+1, eng_start at T+2, rsp_valid with rsp_id=0, rsp_err=0, data = model output; jobs_done=1.
- Fairness: both requesters held valid for 6 jobs. Required: grant order 0,1,0,1,0,1, with exactly one idle cycle between jobs.
- Backpressure: rsp_ready=0 for 20 cycles in DONE. Required: rsp fields stable, req_ready=0 throughout, and eng_fin changes ignored.
- Timeout: engine model never asserts fin, TIMEOUT=64. Required: rsp_valid at T+67, rsp_err=1, rsp_data=0. The next job still runs correctly.
- Stale fin and reset: eng_fin held high across CLEAR/LAUNCH must not complete the job early. Asserting reset in WAIT must return to IDLE with no response, jobs_done unchanged, and requester 0 first on the next grant.
